// File: rtl/mode_seq_pkg.sv
// Shared types and constants for the mode sequencer: one-hot FSM states,
// the legal operating modes and a one-hot legality helper.
package mode_seq_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOW  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_HIGH = 3'd2;
    localparam logic [MODE_W-1:0] MODE_PRIV = 3'd3;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_CHECK  = 6'b000010,
        S_STEP   = 6'b000100,
        S_SETTLE = 6'b001000,
        S_DONE   = 6'b010000,
        S_FAULT  = 6'b100000
    } state_t;

    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/mode_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 with
// wrap-around and returns the first active requester.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_valid
);

    // Priority search starting just after the previous grantee
    always_comb begin
        int w_idx;
        w_idx       = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = (int'(i_last_grant) + i) % N_REQ;
            if (!o_valid && i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant_idx    = IDX_W'(w_idx);
                o_grant[w_idx] = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// Owns the operating-mode register: arbitrates requesters, walks the mode one
// legal step at a time with settling, enforces the mode-3 lock, latches faults.
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [3*N_REQ-1:0]    req_mode,
    input  logic                  lock,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      err,
    output logic [MODE_W-1:0]     mode_out,
    output logic                  busy,
    output logic                  fault
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             r_state;
    logic [MODE_W-1:0]  r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_gidx;
    logic [MODE_W-1:0]  r_target;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ-1:0]   r_err;
    logic               r_busy;
    logic               r_fault;

    state_t             w_state_next;
    logic [MODE_W-1:0]  w_mode_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [IDX_W-1:0]   w_last_next;
    logic [IDX_W-1:0]   w_gidx_next;
    logic [MODE_W-1:0]  w_target_next;
    logic [N_REQ-1:0]   w_ack_next;
    logic [N_REQ-1:0]   w_err_next;
    logic [N_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_valid;
    logic [N_REQ-1:0]   w_grant_bit;
    logic               w_abort;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .i_req        (req),
        .i_last_grant (r_last),
        .o_grant      (w_grant),
        .o_grant_idx  (w_gidx),
        .o_valid      (w_valid)
    );

    assign w_grant_bit = N_REQ'(1) << r_gidx;
    assign w_abort     = (r_target == MODE_PRIV) && lock;

    // Next-state, mode and handshake decode
    always_comb begin
        w_state_next  = r_state;
        w_mode_next   = r_mode;
        w_cnt_next    = r_cnt;
        w_last_next   = r_last;
        w_gidx_next   = r_gidx;
        w_target_next = r_target;
        w_ack_next    = '0;
        w_err_next    = '0;
        if (!is_onehot6(r_state) || (r_mode > MODE_PRIV)) begin
            w_state_next = S_FAULT;
            w_mode_next  = MODE_OFF;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        w_gidx_next   = w_gidx;
                        w_target_next = req_mode[w_gidx*MODE_W +: MODE_W];
                        w_state_next  = S_CHECK;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                S_CHECK: begin
                    if ((r_target > MODE_PRIV) || w_abort) begin
                        w_err_next   = w_grant_bit;
                        w_last_next  = r_gidx;
                        w_state_next = S_IDLE;
                    end else if (r_target == r_mode) begin
                        w_ack_next   = w_grant_bit;
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_STEP;
                    end
                end
                S_STEP: begin
                    if (w_abort) begin
                        w_mode_next  = MODE_OFF;
                        w_err_next   = w_grant_bit;
                        w_last_next  = r_gidx;
                        w_state_next = S_IDLE;
                    end else begin
                        // Downgrades always fall to OFF first, then climb
                        w_mode_next  = (r_target > r_mode) ? (r_mode + 3'd1) : MODE_OFF;
                        w_cnt_next   = CNT_W'(SETTLE_CYC - 1);
                        w_state_next = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_abort) begin
                        w_mode_next  = MODE_OFF;
                        w_err_next   = w_grant_bit;
                        w_last_next  = r_gidx;
                        w_state_next = S_IDLE;
                    end else if (r_cnt == '0) begin
                        if (r_mode == r_target) begin
                            w_ack_next   = w_grant_bit;
                            w_state_next = S_DONE;
                        end else begin
                            w_state_next = S_STEP;
                        end
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    w_last_next  = r_gidx;
                    w_state_next = S_IDLE;
                end
                S_FAULT: begin
                    w_mode_next  = MODE_OFF;
                    w_state_next = S_FAULT;
                end
                default: begin
                    w_mode_next  = MODE_OFF;
                    w_state_next = S_FAULT;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mode   <= MODE_OFF;
            r_cnt    <= '0;
            r_last   <= IDX_W'(N_REQ - 1);
            r_gidx   <= '0;
            r_target <= MODE_OFF;
            r_ack    <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_mode   <= w_mode_next;
            r_cnt    <= w_cnt_next;
            r_last   <= w_last_next;
            r_gidx   <= w_gidx_next;
            r_target <= w_target_next;
            r_ack    <= w_ack_next;
            r_err    <= w_err_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_fault  <= (w_state_next == S_FAULT);
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign mode_out = r_mode;
    assign busy     = r_busy;
    assign fault    = r_fault;

endmodule
